// File: rtl/dcache_frame_pkg.sv
// Shared types and constants for the Dcache2Frame reader: FSM encoding,
// per-beat frame markers and a counter-width helper.
package dcache_frame_pkg;

    // Default width of the completed-frame counter.
    localparam int FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } frame_state_e;

    // Frame markers attached to each word when it enters the skid buffer.
    // The word itself travels next to the tag so the data width stays a
    // per-instance parameter.
    typedef struct packed {
        logic sop;
        logic eop;
    } beat_tag_t;

    localparam int TAG_W = $bits(beat_tag_t);

    // Width of an index counting 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_skid_buf.sv
// Two-entry register FIFO that absorbs the words already requested from the
// Dcache2Frame FIFO while the downstream consumer is stalled.
module frame_skid_buf
    import dcache_frame_pkg::*;
#(
    parameter int W = 32 + TAG_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   cnt
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pop_ok;
    logic         push_ok;

    // Pointer, occupancy and storage update for one push and/or one pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        // A pop on an empty buffer or a push into a full one that is not
        // draining this cycle is ignored rather than corrupting state.
        pop_ok  = pop && (cnt_q != 2'd0);
        push_ok = push && ((cnt_q != 2'd2) || pop_ok);

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign cnt  = cnt_q;

endmodule

// File: rtl/dcache_frame_reader.sv
// Drains the Dcache2Frame FIFO read port and re-emits its words as
// fixed-length frames on a valid/ready stream with SOP/EOP markers.
module dcache_frame_reader
    import dcache_frame_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH_W        = 10,
    parameter int FRAME_LEN      = 256,
    parameter int START_ON_LEVEL = 1,
    parameter int FCNT_W         = FRAME_CNT_W
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              enable,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_empty,
    input  logic [DEPTH_W:0]  fifo_rd_water_level,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sop,
    output logic              m_eop,
    output logic              busy,
    output logic              underrun,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int ISS_W  = $clog2(FRAME_LEN + 1);
    localparam int BEAT_W = cnt_w(FRAME_LEN);
    localparam int SKID_W = DATA_W + TAG_W;

    localparam logic [DEPTH_W:0] LVL_NEED = (DEPTH_W + 1)'(FRAME_LEN);
    localparam logic [ISS_W-1:0] ISS_LAST = ISS_W'(FRAME_LEN - 1);
    localparam logic [ISS_W-1:0] ISS_FULL = ISS_W'(FRAME_LEN);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FRAME_LEN - 1);

    frame_state_e      state_q, state_d;
    logic [ISS_W-1:0]  issued_q, issued_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              inflight_q, inflight_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic [1:0]        skid_cnt;
    logic [SKID_W-1:0] skid_head;
    logic [SKID_W-1:0] skid_push_word;
    beat_tag_t         head_tag;
    logic [DATA_W-1:0] head_data;
    beat_tag_t         push_tag;

    logic              pop;
    logic              eop_hs;
    logic              start_ok;
    logic              credit_ok;
    logic [2:0]        occupancy;
    logic              rd_en;

    // Words land in the skid the cycle after their read; the beat index
    // decides the markers at that moment.
    assign push_tag.sop   = (beat_q == '0);
    assign push_tag.eop   = (beat_q == BEAT_LAST);
    assign skid_push_word = {push_tag, fifo_rd_data};

    frame_skid_buf #(
        .W (SKID_W)
    ) u_skid (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (inflight_q),
        .push_data (skid_push_word),
        .pop       (pop),
        .head      (skid_head),
        .cnt       (skid_cnt)
    );

    assign {head_tag, head_data} = skid_head;

    assign m_valid = (skid_cnt != 2'd0);
    assign pop     = m_valid && m_ready;
    assign eop_hs  = pop && head_tag.eop;

    // Read-issue and handshake decisions for the current cycle.
    always_comb begin
        start_ok = (START_ON_LEVEL != 0) ? (fifo_rd_water_level >= LVL_NEED)
                                         : !fifo_rd_empty;

        // Words held plus the word still in flight must leave room for the
        // new one; a beat leaving this cycle frees its slot in time, which
        // keeps one word per cycle flowing while m_ready stays high.
        occupancy = {1'b0, skid_cnt} + {2'b00, inflight_q};
        credit_ok = occupancy < (3'd2 + {2'b00, pop});

        rd_en = (state_q == ST_STREAM) && !fifo_rd_empty &&
                (issued_q != ISS_FULL) && credit_ok;
    end

    // Frame sequencing FSM plus the issue, beat and frame counters.
    always_comb begin
        state_d     = state_q;
        issued_d    = issued_q;
        beat_d      = beat_q;
        inflight_d  = rd_en;
        frame_cnt_d = frame_cnt_q;

        if (rd_en) begin
            issued_d = issued_q + ISS_W'(1);
        end

        if (inflight_q) begin
            beat_d = push_tag.eop ? '0 : beat_q + BEAT_W'(1);
        end

        if (eop_hs) begin
            frame_cnt_d = frame_cnt_q + FCNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (start_ok) begin
                    state_d  = ST_STREAM;
                    issued_d = '0;
                end
            end
            ST_STREAM: begin
                if (rd_en && (issued_q == ISS_LAST)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (eop_hs) begin
                    state_d = enable ? ST_ARM : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers; reset also discards a read that was in flight.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q     <= ST_IDLE;
            issued_q    <= '0;
            beat_q      <= '0;
            inflight_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            beat_q      <= beat_d;
            inflight_q  <= inflight_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign fifo_rd_en = rd_en;
    assign m_data     = head_data;
    assign m_sop      = m_valid && head_tag.sop;
    assign m_eop      = m_valid && head_tag.eop;
    assign busy       = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
    assign frame_cnt  = frame_cnt_q;

    // Starved mid-frame: nothing left to read, nothing buffered, nothing coming.
    assign underrun = (state_q == ST_STREAM) && (issued_q != '0) &&
                      fifo_rd_empty && (skid_cnt == 2'd0) && !inflight_q;

endmodule

// File: tb/tb_dcache_frame_reader.sv
// Bench for dcache_frame_reader: two instances (level-gated start and
// non-empty start) each fed by a 1-cycle-latency FIFO model, with an
// expected-beat queue filled on every FIFO write and drained on handshakes.
module tb_dcache_frame_reader;

    localparam int FL = 8;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [31:0] data;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rd_rst;
    logic m_ready;
    logic en_a, en_b;

    logic        rd_en_a, rd_en_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        empty_a = 1'b1;
    logic        empty_b = 1'b1;
    logic [10:0] level_a = '0;
    logic [10:0] level_b = '0;
    logic        m_valid_a, m_valid_b;
    logic [31:0] m_data_a, m_data_b;
    logic        sop_a, sop_b, eop_a, eop_b;
    logic        busy_a, busy_b, und_a, und_b;
    logic [15:0] fcnt_a, fcnt_b;

    beat_t       exp_a[$];
    beat_t       exp_b[$];
    logic [31:0] q_a[$];
    logic [31:0] wq_a[$];
    logic [31:0] q_b[$];
    logic [31:0] wq_b[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int na = 0;
    int nb = 0;
    int sop_cyc_a = 0;
    int eop_cyc_a = 0;
    bit    hold_a = 1'b0;
    beat_t held_a;

    dcache_frame_reader #(
        .DATA_W(32), .DEPTH_W(10), .FRAME_LEN(FL), .START_ON_LEVEL(1), .FCNT_W(16)
    ) dut_a (
        .rd_clk(clk), .rd_rst(rd_rst), .enable(en_a),
        .fifo_rd_en(rd_en_a), .fifo_rd_data(rd_data_a), .fifo_rd_empty(empty_a),
        .fifo_rd_water_level(level_a),
        .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a),
        .m_sop(sop_a), .m_eop(eop_a), .busy(busy_a), .underrun(und_a),
        .frame_cnt(fcnt_a)
    );

    dcache_frame_reader #(
        .DATA_W(32), .DEPTH_W(10), .FRAME_LEN(FL), .START_ON_LEVEL(0), .FCNT_W(16)
    ) dut_b (
        .rd_clk(clk), .rd_rst(rd_rst), .enable(en_b),
        .fifo_rd_en(rd_en_b), .fifo_rd_data(rd_data_b), .fifo_rd_empty(empty_b),
        .fifo_rd_water_level(level_b),
        .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b),
        .m_sop(sop_b), .m_eop(eop_b), .busy(busy_b), .underrun(und_b),
        .frame_cnt(fcnt_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model A: data appears one cycle after rd_en; writes land on the next edge.
    always @(posedge clk or posedge rd_rst) begin
        if (rd_rst) begin
            q_a.delete();
            wq_a.delete();
            rd_data_a <= '0;
        end else begin
            if (rd_en_a) begin
                check("a_read_nonempty", q_a.size() != 0, 1);
                if (q_a.size() != 0) rd_data_a <= q_a.pop_front();
            end
            while (wq_a.size() != 0) q_a.push_back(wq_a.pop_front());
        end
        empty_a <= (q_a.size() == 0);
        level_a <= 11'(q_a.size());
    end

    // FIFO model B.
    always @(posedge clk or posedge rd_rst) begin
        if (rd_rst) begin
            q_b.delete();
            wq_b.delete();
            rd_data_b <= '0;
        end else begin
            if (rd_en_b) begin
                check("b_read_nonempty", q_b.size() != 0, 1);
                if (q_b.size() != 0) rd_data_b <= q_b.pop_front();
            end
            while (wq_b.size() != 0) q_b.push_back(wq_b.pop_front());
        end
        empty_b <= (q_b.size() == 0);
        level_b <= 11'(q_b.size());
    end

    // Scoreboard A: compare each accepted beat, and check stall stability.
    always @(negedge clk) begin
        if (rd_rst) begin
            hold_a = 1'b0;
        end else begin
            if (hold_a) begin
                check("a_hold_valid", m_valid_a, 1);
                check("a_hold_beat", {sop_a, eop_a, m_data_a}, held_a);
            end
            hold_a = m_valid_a && !m_ready;
            held_a = {sop_a, eop_a, m_data_a};
            if (m_valid_a && m_ready) begin
                check("a_beat_expected", exp_a.size() != 0, 1);
                if (exp_a.size() != 0) begin
                    beat_t e;
                    e = exp_a.pop_front();
                    check("a_data", m_data_a, e.data);
                    check("a_sop", sop_a, e.sop);
                    check("a_eop", eop_a, e.eop);
                    if (e.sop) sop_cyc_a = cyc;
                    if (e.eop) eop_cyc_a = cyc;
                end
            end
        end
    end

    // Scoreboard B.
    always @(negedge clk) begin
        if (!rd_rst && m_valid_b && m_ready) begin
            check("b_beat_expected", exp_b.size() != 0, 1);
            if (exp_b.size() != 0) begin
                beat_t e;
                e = exp_b.pop_front();
                check("b_data", m_data_b, e.data);
                check("b_sop", sop_b, e.sop);
                check("b_eop", eop_b, e.eop);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_a(input logic [31:0] v, input bit expect_out);
        beat_t e;
        wq_a.push_back(v);
        if (expect_out) begin
            e.sop  = ((na % FL) == 0);
            e.eop  = ((na % FL) == FL - 1);
            e.data = v;
            exp_a.push_back(e);
            na++;
        end
    endtask

    task automatic write_b(input logic [31:0] v);
        beat_t e;
        wq_b.push_back(v);
        e.sop  = ((nb % FL) == 0);
        e.eop  = ((nb % FL) == FL - 1);
        e.data = v;
        exp_b.push_back(e);
        nb++;
    endtask

    // Run until A's expected queue is empty, optionally toggling m_ready.
    task automatic drain_a(input string tag, input int budget, input bit rnd, output int und_seen);
        int i;
        i = 0;
        und_seen = 0;
        while (exp_a.size() != 0 && i < budget) begin
            @(negedge clk);
            if (und_a) und_seen++;
            @(posedge clk);
            #1;
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            i++;
        end
        m_ready = 1'b1;
        check(tag, exp_a.size(), 0);
    endtask

    task automatic drain_b(input string tag, input int budget);
        int i;
        i = 0;
        while (exp_b.size() != 0 && i < budget) begin
            tick(1);
            i++;
        end
        check(tag, exp_b.size(), 0);
    endtask

    task automatic wait_a_left(input string tag, input int left, input int budget);
        int i;
        i = 0;
        while (exp_a.size() > left && i < budget) begin
            tick(1);
            i++;
        end
        check(tag, exp_a.size() <= left, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int und_seen;
        int cnt_rd;
        int cnt_v;
        int c0;
        int lat;
        int base;

        rd_rst  = 1'b1;
        en_a    = 1'b0;
        en_b    = 1'b0;
        m_ready = 1'b1;
        tick(3);
        check("rst_valid", m_valid_a, 0);
        check("rst_rd_en", rd_en_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_frame_cnt", fcnt_a, 0);
        check("rst_data", m_data_a, 0);
        check("rst_markers", {sop_a, eop_a, und_a}, 0);
        rd_rst = 1'b0;
        tick(2);

        // Test 1: one preloaded frame at full rate.
        for (int i = 0; i < FL; i++) write_a(32'(i), 1'b1);
        en_a = 1'b1;
        drain_a("t1_drain", 100, 1'b0, und_seen);
        check("t1_burst_cycles", eop_cyc_a - sop_cyc_a, FL - 1);
        check("t1_frame_cnt", fcnt_a, 1);
        check("t1_busy_low", busy_a, 0);

        // Test 2: level one short of a frame holds the start.
        for (int i = 0; i < FL - 1; i++) write_a(32'h10 + 32'(i), 1'b1);
        cnt_rd = 0;
        cnt_v  = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd_en_a) cnt_rd++;
            if (m_valid_a) cnt_v++;
        end
        check("t2_no_read", cnt_rd, 0);
        check("t2_no_valid", cnt_v, 0);
        @(posedge clk);
        #1;
        write_a(32'h17, 1'b1);
        c0  = cyc;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rd_en_a) begin
                lat = cyc - c0;
                break;
            end
        end
        check("t2_start_latency", lat, 2);
        drain_a("t2_drain", 100, 1'b0, und_seen);
        check("t2_frame_cnt", fcnt_a, 2);

        // Test 3: four back-to-back frames under random backpressure.
        base = int'(fcnt_a);
        for (int i = 0; i < 4 * FL; i++) write_a(32'h1000 + 32'(i), 1'b1);
        drain_a("t3_drain", 1000, 1'b1, und_seen);
        check("t3_frames", int'(fcnt_a) - base, 4);
        check("t3_no_underrun", und_seen, 0);
        en_a = 1'b0;
        tick(3);
        check("t3_idle", busy_a, 0);

        // Test 4: non-empty start, FIFO starves after three words.
        for (int i = 0; i < 3; i++) write_b(32'h2000 + 32'(i));
        en_b = 1'b1;
        und_seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (und_b) und_seen++;
        end
        check("t4_underrun_seen", und_seen > 0, 1);
        check("t4_three_beats", exp_b.size(), 0);
        check("t4_busy_starved", busy_b, 1);
        @(posedge clk);
        #1;
        for (int i = 3; i < FL; i++) write_b(32'h2000 + 32'(i));
        drain_b("t4_drain", 100);
        tick(2);
        check("t4_frame_cnt", fcnt_b, 1);
        en_b = 1'b0;
        tick(3);
        check("t4_idle", busy_b, 0);

        // Test 5: reset in the middle of a frame.
        for (int i = 0; i < FL; i++) write_a(32'h100 + 32'(i), 1'b1);
        en_a = 1'b1;
        wait_a_left("t5_reach_beat4", 3, 100);
        rd_rst = 1'b1;
        #1;
        check("t5_valid", m_valid_a, 0);
        check("t5_rd_en", rd_en_a, 0);
        check("t5_busy", busy_a, 0);
        check("t5_frame_cnt", fcnt_a, 0);
        check("t5_outputs", {sop_a, eop_a, und_a, m_data_a}, 0);
        exp_a.delete();
        na = 0;
        tick(2);
        rd_rst = 1'b0;
        tick(1);
        for (int i = 0; i < FL; i++) write_a(32'h200 + 32'(i), 1'b1);
        drain_a("t5_drain", 100, 1'b0, und_seen);
        check("t5_frame_cnt_after", fcnt_a, 1);

        // Test 6: enable dropped at beat 2 finishes the frame only.
        for (int i = 0; i < 2 * FL; i++) write_a(32'h300 + 32'(i), i < FL);
        wait_a_left("t6_reach_beat2", FL - 3, 100);
        en_a = 1'b0;
        drain_a("t6_drain", 100, 1'b0, und_seen);
        check("t6_frame_cnt", fcnt_a, 2);
        tick(2);
        check("t6_busy", busy_a, 0);
        cnt_rd = 0;
        repeat (12) begin
            @(negedge clk);
            if (rd_en_a) cnt_rd++;
        end
        check("t6_no_read", cnt_rd, 0);
        check("t6_fifo_left", q_a.size(), FL);
        check("t6_valid_low", m_valid_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
